load_run_dump_ctrl: RTL and testbench
=====================================

# load_run_dump_ctrl

Synthesizable, parametrised successor to the CPU bench harness. It streams a byte-wide program image into the CPU's RAM while holding the CPU in reset. It then runs the CPU until a halt indication or a cycle budget expires. Finally it streams out a configurable memory window (big-endian words) followed by the register file. It sits between the CPU top and an external host/bench and owns the CPU's reset and run-enable.

## Interface
- ADDR_W, 8: RAM byte-address width.
- NREGS, 16: register-file entries to dump (index width RSEL_W = clog2(NREGS)).
- DUMP_BASE, 0: first byte address of the memory dump window (word-aligned).
- DUMP_WORDS, 63: number of 32-bit words dumped.
- MAX_CYCLES, 1024: run-phase cycle budget (counter width clog2(MAX_CYCLES+1)).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  begin load phase; sampled only in IDLE.
- ld_valid / ld_ready  in / out  1 / 1  program-byte handshake.
- ld_data  in  8  program byte.
- ld_last  in  1  marks final byte of image.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_we  out  1  RAM write strobe.
- mem_rdata  in  8  RAM read byte, valid 1 cycle after mem_addr.
- cpu_clr  out  1  held-reset to CPU.
- cpu_run  out  1  CPU clock-enable.
- cpu_halt  in  1  CPU fetched an invalid/halt instruction.
- reg_sel  out  RSEL_W  register-file read select.
- reg_rdata  in  32  register read data, combinational from reg_sel.
- dump_valid / dump_ready  out / in  1 / 1  dump handshake.
- dump_data  out  32  dumped word.
- dump_kind  out  1  0 = memory word, 1 = register.
- dump_idx  out  ADDR_W  byte address (mem) or register index (reg, zero-extended).
- done, timeout, overflow  out  1 each  sticky status.
- byte_count  out  ADDR_W+1  bytes loaded.

## Operation
- States: IDLE -> LOAD -> RUN -> DMEM -> DREG -> DONE. DONE returns to IDLE on start, which clears the status flags and byte_count.
- IDLE: cpu_clr=1, cpu_run=0, ld_ready=0.
- LOAD: ld_ready=1. Each accepted byte (ld_valid&ld_ready) produces mem_we=1, mem_wdata=ld_data, mem_addr=byte_count[ADDR_W-1:0] in the same cycle; byte_count then increments.
  - Leaving LOAD: the accepted byte carries ld_last, or byte_count reaches 2^ADDR_W. In the second case overflow=1 and ld_ready drops.
- RUN: cpu_clr=0, cpu_run=1, cycle counter increments each cycle.
  - cpu_halt=1 ends RUN.
  - The counter reaching MAX_CYCLES ends RUN with timeout=1.
  - cpu_halt and budget expiring in the same cycle: halt wins, timeout stays 0.
  - After RUN, cpu_run=0 and cpu_clr stays 0 (state preserved for dump).
- DMEM: for word w (0..DUMP_WORDS-1), reads bytes at A=DUMP_BASE+4w .. A+3, with addresses wrapping modulo 2^ADDR_W. Assembles dump_data = {M[A],M[A+1],M[A+2],M[A+3]}, dump_kind=0, dump_idx=A.
- DREG: reg_sel=r for r=0..NREGS-1; dump_data=reg_rdata captured, dump_kind=1, dump_idx=r.
- DONE: done=1, cpu_run=0.
- start outside IDLE/DONE is ignored. mem_we is never asserted outside LOAD.

## Timing
- Reset values: ld_ready=0, mem_addr=0, mem_wdata=0, mem_we=0, cpu_clr=1, cpu_run=0, reg_sel=0, dump_valid=0, dump_data=0, dump_kind=0, dump_idx=0, done=0, timeout=0, overflow=0, byte_count=0, state IDLE.
- start in IDLE -> ld_ready=1 next cycle. Load throughput is 1 byte/cycle.
- The last load byte is written in its accept cycle; RUN begins the following cycle.
- Exactly N run cycles have cpu_run=1, where N = halt-detect cycle count (halt cycle included) or MAX_CYCLES.
- DMEM per word: addresses issued on cycles 0..3, bytes captured on cycles 1..4, dump_valid=1 from cycle 5. dump_valid holds with dump_data stable until dump_ready. The next word's fetch starts the cycle after the handshake. Zero-stall cost is 6 cycles/word.
- DREG per register: reg_sel set on cycle 0, data captured with dump_valid=1 on cycle 1, held until dump_ready.
- dump_ready ignored while dump_valid=0.
- clr mid-operation: all outputs return to reset values immediately (asynchronous), including cpu_clr=1. Any in-flight dump word is discarded.

## Structure
- Package load_run_dump_pkg: state enum, DUMP_KIND_MEM/DUMP_KIND_REG constants, WORD_BYTES=4.
- One sub-module: byte_word_packer. It shifts in 8-bit bytes MSB-first, emits a 32-bit word plus a full flag after 4 bytes, and clears on take.

## Test plan
- Load 8 bytes 0x00,0x01..0x07 (ld_last on 8th) -> RAM[0..7]=0..7, byte_count=8, cpu_run rises the cycle after the 8th accept.
- cpu_halt at run cycle 20, MAX_CYCLES=1024 -> cpu_run high exactly 20 cycles, timeout=0.
- cpu_halt never asserted, MAX_CYCLES=16 -> 16 run cycles, timeout=1, dump proceeds.
- RAM[0..3]=0xE3,0xA0,0x10,0x04, DUMP_BASE=0 -> first dump_data=0xE3A01004, dump_idx=0, dump_kind=0. With dump_ready held low for 10 cycles, data is stable throughout.
- ADDR_W=4, stream 17 bytes without ld_last -> 16 bytes written, overflow=1, ld_ready drops. After DMEM the registers R0..R15 are dumped with dump_kind=1, then done=1.
- clr pulsed mid-DMEM -> all outputs at reset values, cpu_clr=1. A subsequent start reloads cleanly.

Source files
------------

// File: rtl/load_run_dump_pkg.sv
`default_nettype none
// ============================================================================
// Package : load_run_dump_pkg
// Shared states and constants for the load/run/dump controller.
// Revision: 1.0
// ============================================================================
package load_run_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DMEM = 3'd3,
    ST_DREG = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic DUMP_KIND_MEM = 1'b0;
  localparam logic DUMP_KIND_REG = 1'b1;
  localparam int   WORD_BYTES    = 4;

endpackage
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module : byte_word_packer
// Shifts bytes in MSB-first; flags a full 32-bit word, cleared on take.
// Revision: 1.0
// ============================================================================
module byte_word_packer
  import load_run_dump_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        take,
  output logic [31:0] word,
  output logic        full
);

  logic [2:0]  r_cnt;
  logic [31:0] r_word;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (take) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (in_valid && !full) begin
      r_word <= {r_word[23:0], in_byte};
      r_cnt  <= r_cnt + 3'd1;
    end
  end

  assign word = r_word;
  assign full = (r_cnt == 3'(WORD_BYTES));

endmodule
`default_nettype wire

// File: rtl/load_run_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module : load_run_dump_ctrl
// Loads a program image into CPU RAM, runs the CPU, then dumps RAM and regs.
// Revision: 1.0
// ============================================================================
module load_run_dump_ctrl
  import load_run_dump_pkg::*;
#(
  parameter int  ADDR_W     = 8,
  parameter int  NREGS      = 16,
  parameter int  DUMP_BASE  = 0,
  parameter int  DUMP_WORDS = 63,
  parameter int  MAX_CYCLES = 1024,
  localparam int RSEL_W     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_clr,
  output logic              cpu_run,
  input  logic              cpu_halt,
  output logic [RSEL_W-1:0] reg_sel,
  input  logic [31:0]       reg_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic              dump_kind,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
);

  localparam int              CYC_W        = $clog2(MAX_CYCLES + 1);
  localparam int              WCNT_W       = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [ADDR_W:0] c_last_slot  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [2:0]      c_phase_wait = 3'(WORD_BYTES + 1);

  state_t              r_state, w_next;
  logic [ADDR_W:0]     r_byte_count;
  logic                r_timeout, r_overflow;
  logic [CYC_W-1:0]    r_cyc;
  logic [2:0]          r_phase;
  logic [WCNT_W-1:0]   r_word;
  logic [ADDR_W-1:0]   r_addr;
  logic [RSEL_W-1:0]   r_reg;
  logic                r_reg_valid;
  logic [31:0]         r_reg_data;
  logic [31:0]         w_pk_word;
  logic                w_pk_full;

  wire w_accept    = (r_state == ST_LOAD) && ld_valid;
  wire w_last_cyc  = (r_cyc == CYC_W'(MAX_CYCLES - 1));
  wire w_mem_take  = (r_state == ST_DMEM) && w_pk_full && dump_ready;
  wire w_reg_take  = (r_state == ST_DREG) && r_reg_valid && dump_ready;
  wire w_last_word = (r_word == WCNT_W'(DUMP_WORDS - 1));
  wire w_last_reg  = (r_reg == RSEL_W'(NREGS - 1));
  wire w_restart   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Phases 1..4 each capture the byte addressed in the previous phase.
  wire w_pk_shift  = (r_state == ST_DMEM) && (r_phase != 3'd0) &&
                     (r_phase <= 3'(WORD_BYTES));

  byte_word_packer u_packer (
    .clk      (clk),
    .clr      (clr),
    .in_valid (w_pk_shift),
    .in_byte  (mem_rdata),
    .take     (w_mem_take),
    .word     (w_pk_word),
    .full     (w_pk_full)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_addr   = '0;
    cpu_clr    = 1'b0;
    cpu_run    = 1'b0;
    reg_sel    = '0;
    dump_valid = 1'b0;
    dump_data  = '0;
    dump_kind  = DUMP_KIND_MEM;
    dump_idx   = '0;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cpu_clr = 1'b1;
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        cpu_clr   = 1'b1;
        ld_ready  = 1'b1;
        mem_we    = ld_valid;
        mem_addr  = r_byte_count[ADDR_W-1:0];
        mem_wdata = ld_valid ? ld_data : 8'h00;
        if (w_accept && (ld_last || r_byte_count == c_last_slot)) w_next = ST_RUN;
      end
      ST_RUN: begin
        cpu_run = 1'b1;
        if (cpu_halt || w_last_cyc) w_next = ST_DMEM;
      end
      ST_DMEM: begin
        mem_addr   = r_addr + ADDR_W'(r_phase);
        dump_valid = w_pk_full;
        dump_data  = w_pk_full ? w_pk_word : 32'h0;
        dump_idx   = r_addr;
        if (w_mem_take && w_last_word) w_next = ST_DREG;
      end
      ST_DREG: begin
        reg_sel    = r_reg;
        dump_valid = r_reg_valid;
        dump_data  = r_reg_valid ? r_reg_data : 32'h0;
        dump_kind  = DUMP_KIND_REG;
        dump_idx   = ADDR_W'(r_reg);
        if (w_reg_take && w_last_reg) w_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_byte_count <= '0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_cyc        <= '0;
      r_phase      <= '0;
      r_word       <= '0;
      r_addr       <= '0;
      r_reg        <= '0;
      r_reg_valid  <= 1'b0;
      r_reg_data   <= '0;
    end else begin
      if (w_restart) begin
        r_byte_count <= '0;
        r_timeout    <= 1'b0;
        r_overflow   <= 1'b0;
      end
      if (w_accept) begin
        r_byte_count <= r_byte_count + (ADDR_W+1)'(1);
        if (!ld_last && r_byte_count == c_last_slot) r_overflow <= 1'b1;
      end
      // A halt in the budget's final cycle takes priority over timeout.
      if (r_state == ST_RUN) begin
        r_cyc <= r_cyc + CYC_W'(1);
        if (!cpu_halt && w_last_cyc) r_timeout <= 1'b1;
      end else begin
        r_cyc <= '0;
      end
      if (r_state == ST_DMEM) begin
        if (r_phase != c_phase_wait) begin
          r_phase <= r_phase + 3'd1;
        end else if (w_mem_take) begin
          r_phase <= '0;
          r_addr  <= r_addr + ADDR_W'(WORD_BYTES);
          r_word  <= r_word + WCNT_W'(1);
        end
      end else begin
        r_phase <= '0;
        r_word  <= '0;
        r_addr  <= ADDR_W'(DUMP_BASE);
      end
      if (r_state == ST_DREG) begin
        if (!r_reg_valid) begin
          r_reg_data  <= reg_rdata;
          r_reg_valid <= 1'b1;
        end else if (dump_ready) begin
          r_reg_valid <= 1'b0;
          r_reg       <= r_reg + RSEL_W'(1);
        end
      end else begin
        r_reg       <= '0;
        r_reg_valid <= 1'b0;
      end
    end
  end

  assign byte_count = r_byte_count;
  assign timeout    = r_timeout;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_load_run_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_load_run_dump_ctrl
// Directed bench with a dump scoreboard for load_run_dump_ctrl.
// Revision: 1.0
// ============================================================================
module tb_load_run_dump_ctrl;
  import load_run_dump_pkg::*;

  localparam int ADDR_W     = 4;
  localparam int NREGS      = 16;
  localparam int DUMP_BASE  = 0;
  localparam int DUMP_WORDS = 5;
  localparam int MAX_CYCLES = 32;
  localparam int MEM        = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, cpu_halt = 1'b0;
  logic        dump_ready = 1'b0, ram_init = 1'b1;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready, mem_we, cpu_clr, cpu_run, dump_valid, dump_kind;
  logic        done, timeout, overflow;
  logic [ADDR_W-1:0] mem_addr, dump_idx;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [3:0]  reg_sel;
  logic [31:0] reg_rdata, dump_data;
  logic [ADDR_W:0] byte_count;

  typedef struct packed {
    logic              kind;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
  } item_t;

  item_t       exp_q[$];
  logic [7:0]  ram    [MEM];
  logic [7:0]  shadow [MEM];
  logic [7:0]  img    [32];
  logic [31:0] regs   [NREGS];
  int          total = 0, passed = 0, fails = 0;
  int          run_cycles = 0, we_viol = 0, base = 0;

  load_run_dump_ctrl #(
    .ADDR_W(ADDR_W), .NREGS(NREGS), .DUMP_BASE(DUMP_BASE),
    .DUMP_WORDS(DUMP_WORDS), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .cpu_clr(cpu_clr), .cpu_run(cpu_run),
    .cpu_halt(cpu_halt), .reg_sel(reg_sel), .reg_rdata(reg_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_kind(dump_kind), .dump_idx(dump_idx), .done(done), .timeout(timeout),
    .overflow(overflow), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency, plus run/write monitors.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < MEM; i++) ram[i] <= 8'(8'h50 + i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
    if (cpu_run) run_cycles <= run_cycles + 1;
    if (mem_we && !ld_ready) we_viol <= we_viol + 1;
  end

  assign reg_rdata = regs[reg_sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"},
          32'({ld_ready, mem_we, cpu_clr, cpu_run, dump_valid, dump_kind, done, timeout, overflow}),
          32'b0_0100_0000);
    check({tag, "_fields"}, 32'({mem_addr, mem_wdata, reg_sel, dump_idx, byte_count}), 32'h0);
    check({tag, "_dump_data"}, dump_data, 32'h0);
  endtask

  task automatic load_image(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = with_last && (i == n - 1);
      #1;
      if (i < MEM) begin
        check("ld_mem_we", 32'(mem_we), 32'd1);
        check("ld_mem_addr", 32'(mem_addr), 32'(i % MEM));
        check("ld_mem_wdata", 32'(mem_wdata), 32'(img[i]));
        shadow[i] = img[i];
      end else begin
        check("ld_ready_after_full", 32'(ld_ready), 32'd0);
        check("ld_we_after_full", 32'(mem_we), 32'd0);
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 8'h00;
  endtask

  task automatic wait_run_end(input int bound);
    int n = 0;
    while (cpu_run && n < bound) begin
      tick();
      n++;
    end
    check("run_end_in_budget", 32'(cpu_run), 32'd0);
  endtask

  task automatic push_expected();
    item_t it;
    for (int w = 0; w < DUMP_WORDS; w++) begin
      int a = (DUMP_BASE + 4 * w) % MEM;
      it.kind = DUMP_KIND_MEM;
      it.idx  = ADDR_W'(a);
      it.data = {shadow[a], shadow[(a + 1) % MEM], shadow[(a + 2) % MEM], shadow[(a + 3) % MEM]};
      exp_q.push_back(it);
    end
    for (int r = 0; r < NREGS; r++) begin
      it.kind = DUMP_KIND_REG;
      it.idx  = ADDR_W'(r);
      it.data = regs[r];
      exp_q.push_back(it);
    end
  endtask

  // Compares each presented item against the queue head; a stall re-checks it.
  task automatic collect(input int stall, input bit hold_ready);
    int    guard = 0;
    int    stalls = 0;
    item_t e;
    dump_ready = hold_ready;
    while (exp_q.size() > 0 && guard < 3000) begin
      if (dump_valid) begin
        e = exp_q[0];
        check("dump_kind", 32'(dump_kind), 32'(e.kind));
        check("dump_idx", 32'(dump_idx), 32'(e.idx));
        check("dump_data", dump_data, e.data);
        if (stalls < stall) begin
          stalls++;
          dump_ready = 1'b0;
        end else begin
          void'(exp_q.pop_front());
          dump_ready = 1'b1;
        end
      end else if (!hold_ready) begin
        dump_ready = 1'b0;
      end
      tick();
      guard++;
    end
    dump_ready = 1'b0;
    check("dump_items_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) shadow[i] = 8'(8'h50 + i);
    for (int r = 0; r < NREGS; r++) regs[r] = 32'hA500_0000 | 32'(r << 8) | 32'(r * 3);

    repeat (2) tick();
    check_reset("reset_held");
    clr      = 1'b0;
    ram_init = 1'b0;
    tick();
    check_reset("reset_idle");

    // Load 0..7, halt on run cycle 20.
    do_start();
    check("a_ld_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 8; i++) img[i] = 8'(i);
    base = run_cycles;
    load_image(8, 1'b1);
    check("a_cpu_run_rise", 32'(cpu_run), 32'd1);
    check("a_byte_count", 32'(byte_count), 32'd8);
    check("a_ld_ready_low", 32'(ld_ready), 32'd0);
    check("a_cpu_clr_low", 32'(cpu_clr), 32'd0);
    repeat (19) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("a_run_stopped", 32'(cpu_run), 32'd0);
    check("a_run_cycles", 32'(run_cycles - base), 32'd20);
    check("a_timeout", 32'(timeout), 32'd0);
    check("a_cpu_clr_held_low", 32'(cpu_clr), 32'd0);
    push_expected();
    collect(0, 1'b0);
    check("a_done", 32'(done), 32'd1);

    // No halt: budget expires; first word stalled for 10 cycles.
    do_start();
    check("b_status_cleared", 32'({done, timeout, overflow, byte_count}), 32'h0);
    do_start();
    img[0] = 8'hE3; img[1] = 8'hA0; img[2] = 8'h10; img[3] = 8'h04;
    img[4] = 8'h11; img[5] = 8'h22;
    base = run_cycles;
    load_image(6, 1'b1);
    wait_run_end(100);
    check("b_run_cycles", 32'(run_cycles - base), 32'(MAX_CYCLES));
    check("b_timeout", 32'(timeout), 32'd1);
    push_expected();
    check("b_first_word_model", exp_q[0].data, 32'hE3A0_1004);
    collect(10, 1'b0);
    check("b_done_timeout", 32'({done, timeout}), 32'b11);

    // Overflow: 17 bytes without last; halt lands on the budget's final cycle.
    do_start();
    do_start();
    for (int i = 0; i < 17; i++) img[i] = 8'(8'h80 + 3 * i);
    base = run_cycles;
    load_image(17, 1'b0);
    check("c_overflow", 32'(overflow), 32'd1);
    check("c_byte_count", 32'(byte_count), 32'd16);
    check("c_ld_ready", 32'(ld_ready), 32'd0);
    repeat (MAX_CYCLES - 2) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("c_run_cycles", 32'(run_cycles - base), 32'(MAX_CYCLES));
    check("c_halt_wins", 32'(timeout), 32'd0);
    push_expected();
    collect(0, 1'b1);
    check("c_done", 32'(done), 32'd1);

    // clr while a dump word is waiting, then a clean reload.
    do_start();
    do_start();
    for (int i = 0; i < 4; i++) img[i] = 8'(8'h11 * (i + 1));
    base = run_cycles;
    load_image(4, 1'b1);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("d_run_cycles", 32'(run_cycles - base), 32'd1);
    begin
      int n = 0;
      while (!dump_valid && n < 20) begin
        tick();
        n++;
      end
    end
    check("d_valid_before_clr", 32'(dump_valid), 32'd1);
    clr = 1'b1;
    #1;
    check_reset("d_async_clr");
    tick();
    clr = 1'b0;
    exp_q.delete();
    tick();
    check_reset("d_after_clr");
    do_start();
    for (int i = 0; i < 8; i++) img[i] = 8'(8'hF0 + i);
    load_image(8, 1'b1);
    check("d_byte_count", 32'(byte_count), 32'd8);
    repeat (4) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    push_expected();
    collect(0, 1'b0);
    check("d_done_status", 32'({done, timeout, overflow}), 32'b100);
    check("mem_we_outside_load", 32'(we_viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
